// File: rtl/ddr_dimm_cmd_decoder.sv
// DDR4 DIMM-side command bus responder.
// Registers the decoded pin-level command, mirrors the MR0/MR1/MR2 latency fields,
// tracks per-bank open/idle state, flags protocol violations and schedules the
// read-drive / write-capture windows as OR-merged shift registers.
// Optional feature: define DDR_CMD_PARITY_EN to check even command parity on `par`.
module ddr_dimm_cmd_decoder #(
  parameter int unsigned BG_WIDTH  = 2,
  parameter int unsigned BA_WIDTH  = 2,
  parameter int unsigned ROW_WIDTH = 17,
  parameter int unsigned COL_WIDTH = 10,
  parameter int unsigned MAX_LAT   = 48
) (
  input  logic                              clock_t,
  input  logic                              reset,
  input  logic                              cs_n,
  input  logic                              act_n,
  input  logic                              ras_n_a16,
  input  logic                              cas_n_a15,
  input  logic                              we_n_a14,
  input  logic [BG_WIDTH-1:0]               bg,
  input  logic [BA_WIDTH-1:0]               ba,
  input  logic [13:0]                       a,
  input  logic                              par,
  output logic                              cmd_valid,
  output logic [3:0]                        cmd_code,
  output logic [BG_WIDTH+BA_WIDTH-1:0]      cmd_bank,
  output logic [ROW_WIDTH-1:0]              cmd_row,
  output logic [COL_WIDTH-1:0]              cmd_col,
  output logic [4:0]                        cl,
  output logic [4:0]                        cwl,
  output logic [4:0]                        al,
  output logic [3:0]                        bl,
  output logic [2**(BG_WIDTH+BA_WIDTH)-1:0] open_banks,
  output logic                              rd_en,
  output logic                              wr_en,
  output logic                              proto_err,
  output logic                              par_err
);

  localparam int unsigned BankW    = BG_WIDTH + BA_WIDTH;
  localparam int unsigned NumBanks = 2 ** BankW;

  localparam logic [3:0] CmdNop     = 4'd0;
  localparam logic [3:0] CmdAct     = 4'd1;
  localparam logic [3:0] CmdCasR    = 4'd2;
  localparam logic [3:0] CmdCasW    = 4'd3;
  localparam logic [3:0] CmdPre     = 4'd4;
  localparam logic [3:0] CmdRef     = 4'd5;
  localparam logic [3:0] CmdMrs     = 4'd6;
  localparam logic [3:0] CmdZqcl    = 4'd7;
  localparam logic [3:0] CmdDes     = 4'd8;
  localparam logic [3:0] CmdIllegal = 4'd15;

  typedef enum logic [0:0] {StIdle, StOpen} bank_state_e;

  bank_state_e        bank_q [NumBanks];
  logic [MAX_LAT-1:0] rd_sr_q, wr_sr_q;

  logic [3:0]         code;
  logic               exempt;
  logic               par_bad;
  logic               accept;
  logic               hit_open;
  logic               any_open;
  logic               proto;
  logic [BankW-1:0]   bank_idx;
  logic [BA_WIDTH:0]  mr_idx;
  logic [16:0]        row_raw;
  logic [5:0]         rd_lat, wr_lat;
  logic [MAX_LAT-1:0] burst, rd_mask, wr_mask;

  assign bank_idx = {bg, ba};
  assign mr_idx   = {bg[0], ba};
  assign row_raw  = {ras_n_a16, cas_n_a15, we_n_a14, a};

  // Pin-level command decode.
  always_comb begin
    code = CmdNop;
    if (cs_n) begin
      code = CmdDes;
    end else if (!act_n) begin
      code = CmdAct;
    end else begin
      unique case ({ras_n_a16, cas_n_a15, we_n_a14})
        3'b000:  code = CmdMrs;
        3'b001:  code = CmdRef;
        3'b010:  code = CmdPre;
        3'b011:  code = CmdIllegal;
        3'b100:  code = CmdCasW;
        3'b101:  code = CmdCasR;
        3'b110:  code = a[10] ? CmdZqcl : CmdIllegal;
        default: code = CmdNop;
      endcase
    end
  end

  assign exempt = (code == CmdNop) || (code == CmdDes);

`ifdef DDR_CMD_PARITY_EN
  // Even parity: XOR of the covered pins must equal par.
  assign par_bad = !exempt && ((^{act_n, ras_n_a16, cas_n_a15, we_n_a14, bg, ba, a}) != par);
`else
  logic unused_par;
  assign unused_par = par;
  assign par_bad    = 1'b0;
`endif

  // A command with bad parity is dropped entirely.
  assign accept = !exempt && !par_bad;

  // Per-bank open flags straight from the bank state registers.
  always_comb begin
    open_banks = '0;
    for (int i = 0; i < NumBanks; i++) begin
      open_banks[i] = (bank_q[i] == StOpen);
    end
  end

  assign hit_open = open_banks[bank_idx];
  assign any_open = |open_banks;

  // Violation check against the bank state as it stands before this command.
  always_comb begin
    proto = 1'b0;
    if (accept) begin
      proto = ((code == CmdAct) && hit_open) ||
              (((code == CmdCasR) || (code == CmdCasW)) && !hit_open) ||
              (((code == CmdRef) || (code == CmdMrs)) && any_open) ||
              (code == CmdIllegal);
    end
  end

  // Burst window masks; latency is taken from the registers current at CAS time.
  always_comb begin
    rd_lat  = 6'(al) + 6'(cl);
    wr_lat  = 6'(al) + 6'(cwl);
    burst   = (bl == 4'd4) ? MAX_LAT'(2'b11) : MAX_LAT'(4'hF);
    rd_mask = (accept && (code == CmdCasR)) ? (burst << rd_lat) : '0;
    wr_mask = (accept && (code == CmdCasW)) ? (burst << wr_lat) : '0;
  end

  assign rd_en = rd_sr_q[0];
  assign wr_en = wr_sr_q[0];

  // Registered command outputs, mode-register mirrors and data windows.
  always_ff @(posedge clock_t) begin
    if (reset) begin
      cmd_valid <= 1'b0;
      cmd_code  <= CmdNop;
      cmd_bank  <= '0;
      cmd_row   <= '0;
      cmd_col   <= '0;
      cl        <= 5'd9;
      cwl       <= 5'd9;
      al        <= 5'd0;
      bl        <= 4'd8;
      proto_err <= 1'b0;
      par_err   <= 1'b0;
      rd_sr_q   <= '0;
      wr_sr_q   <= '0;
    end else begin
      cmd_valid <= accept;
      cmd_code  <= par_bad ? CmdNop : code;
      cmd_bank  <= bank_idx;
      cmd_row   <= (accept && (code == CmdAct)) ? ROW_WIDTH'(row_raw) : '0;
      cmd_col   <= (accept && ((code == CmdCasR) || (code == CmdCasW))) ?
                   COL_WIDTH'(a[9:0]) : '0;
      proto_err <= proto;
      par_err   <= par_bad;
      rd_sr_q   <= (rd_sr_q >> 1) | rd_mask;
      wr_sr_q   <= (wr_sr_q >> 1) | wr_mask;
      if (accept && (code == CmdMrs)) begin
        case (int'(mr_idx))
          0: begin
            if (a[6:3] < 4'd12) cl <= 5'd9 + {1'b0, a[6:3]};
            bl <= (a[1:0] == 2'b10) ? 4'd4 : 4'd8;
          end
          1: begin
            // MR1 AL is expressed relative to the CL in force before this command.
            if ((a[4:3] == 2'd1) || (a[4:3] == 2'd2)) al <= cl - {3'b000, a[4:3]};
            else                                      al <= 5'd0;
          end
          2: begin
            if (a[5:3] < 3'd7) cwl <= 5'd9 + {2'b00, a[5:3]};
          end
          default: ;
        endcase
      end
    end
  end

  // Per-bank IDLE/OPEN state machine.
  always_ff @(posedge clock_t) begin
    if (reset) begin
      for (int i = 0; i < NumBanks; i++) bank_q[i] <= StIdle;
    end else if (accept) begin
      for (int i = 0; i < NumBanks; i++) begin
        unique case (bank_q[i])
          StIdle: if ((code == CmdAct) && (BankW'(i) == bank_idx)) bank_q[i] <= StOpen;
          StOpen: if ((code == CmdPre) && (a[10] || (BankW'(i) == bank_idx)))
                    bank_q[i] <= StIdle;
          default: bank_q[i] <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr_dimm_cmd_decoder.sv
// Self-checking bench for ddr_dimm_cmd_decoder: directed scenarios followed by random
// command traffic, all compared every cycle against a behavioural model.
module tb_ddr_dimm_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n, act_n, ras, cas, we;
  logic [1:0]  bg, ba;
  logic [13:0] a;
  logic        par;

  logic        cmd_valid;
  logic [3:0]  cmd_code;
  logic [3:0]  cmd_bank;
  logic [16:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [4:0]  cl, cwl, al;
  logic [3:0]  bl;
  logic [15:0] open_banks;
  logic        rd_en, wr_en, proto_err, par_err;

  always #5 clk = ~clk;

  ddr_dimm_cmd_decoder dut (
    .clock_t    (clk),
    .reset      (rst),
    .cs_n       (cs_n),
    .act_n      (act_n),
    .ras_n_a16  (ras),
    .cas_n_a15  (cas),
    .we_n_a14   (we),
    .bg         (bg),
    .ba         (ba),
    .a          (a),
    .par        (par),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_bank   (cmd_bank),
    .cmd_row    (cmd_row),
    .cmd_col    (cmd_col),
    .cl         (cl),
    .cwl        (cwl),
    .al         (al),
    .bl         (bl),
    .open_banks (open_banks),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .proto_err  (proto_err),
    .par_err    (par_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state.
  int  m_cl, m_cwl, m_al, m_bl;
  bit  m_open [16];
  bit  rd_exp [4096];
  bit  wr_exp [4096];
  bit  e_valid, e_proto, e_par, e_dropped;
  int  e_code, e_bank, e_row, e_col;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_pins(input bit csn, input bit actn, input bit r, input bit c,
                          input bit w, input int bank, input logic [13:0] addr,
                          input bit flip);
    logic [3:0] bk;
    bk    = 4'(bank);
    rst   = 1'b0;
    cs_n  = csn;
    act_n = actn;
    ras   = r;
    cas   = c;
    we    = w;
    bg    = bk[3:2];
    ba    = bk[1:0];
    a     = addr;
    par   = (^{actn, r, c, w, bk, addr}) ^ flip;
  endtask

  task automatic do_nop();                      set_pins(0, 1, 1, 1, 1, 0, 14'h0, 0); endtask
  task automatic do_act(input int b, input logic [16:0] row);
    set_pins(0, 0, row[16], row[15], row[14], b, row[13:0], 0);
  endtask
  task automatic do_rd(input int b, input int col);  set_pins(0, 1, 1, 0, 1, b, 14'(col), 0); endtask
  task automatic do_wr(input int b, input int col);  set_pins(0, 1, 1, 0, 0, b, 14'(col), 0); endtask
  task automatic do_pre(input int b, input bit all);
    set_pins(0, 1, 0, 1, 0, b, all ? 14'h0400 : 14'h0, 0);
  endtask
  task automatic do_ref();                      set_pins(0, 1, 0, 0, 1, 0, 14'h0, 0); endtask
  task automatic do_mrs(input int mr, input logic [13:0] v); set_pins(0, 1, 0, 0, 0, mr, v, 0); endtask

  // Behavioural model of one clock edge using the pins currently driven.
  task automatic model_edge();
    int  code, b, mr, lat, x;
    bit  any;
    b = int'({bg, ba});
    if (rst) begin
      m_cl = 9; m_cwl = 9; m_al = 0; m_bl = 8;
      for (int i = 0; i < 16; i++) m_open[i] = 0;
      for (int i = cyc; i < 4096; i++) begin rd_exp[i] = 0; wr_exp[i] = 0; end
      e_valid = 0; e_proto = 0; e_par = 0; e_dropped = 0;
      e_code = 0; e_bank = 0; e_row = 0; e_col = 0;
      return;
    end
    if (cs_n)        code = 8;
    else if (!act_n) code = 1;
    else begin
      case ({ras, cas, we})
        3'd0: code = 6;
        3'd1: code = 5;
        3'd2: code = 4;
        3'd3: code = 15;
        3'd4: code = 3;
        3'd5: code = 2;
        3'd6: code = a[10] ? 7 : 15;
        default: code = 0;
      endcase
    end
    e_par = 0;
`ifdef DDR_CMD_PARITY_EN
    if (code != 0 && code != 8 && ((^{act_n, ras, cas, we, bg, ba, a}) != par)) e_par = 1;
`endif
    e_dropped = e_par;
    if (e_par) begin
      e_valid = 0; e_proto = 0;
      return;
    end
    e_valid = (code != 0) && (code != 8);
    e_code  = code;
    e_bank  = b;
    e_row   = (code == 1) ? int'({ras, cas, we, a}) : 0;
    e_col   = (code == 2 || code == 3) ? int'(a[9:0]) : 0;
    any = 0;
    for (int i = 0; i < 16; i++) any |= m_open[i];
    e_proto = (code == 1 && m_open[b]) || ((code == 2 || code == 3) && !m_open[b]) ||
              ((code == 5 || code == 6) && any) || (code == 15);
    if (code == 2 || code == 3) begin
      lat = m_al + ((code == 2) ? m_cl : m_cwl);
      for (int k = 0; k < m_bl / 2; k++) begin
        if (code == 2) rd_exp[cyc + lat + k] = 1;
        else           wr_exp[cyc + lat + k] = 1;
      end
    end
    if (code == 1) m_open[b] = 1;
    if (code == 4) begin
      if (a[10]) for (int i = 0; i < 16; i++) m_open[i] = 0;
      else       m_open[b] = 0;
    end
    if (code == 6) begin
      mr = int'({bg[0], ba});
      if (mr == 0) begin
        if (a[6:3] < 12) m_cl = 9 + int'(a[6:3]);
        m_bl = (a[1:0] == 2'b10) ? 4 : 8;
      end else if (mr == 1) begin
        x = int'(a[4:3]);
        m_al = (x == 1 || x == 2) ? m_cl - x : 0;
      end else if (mr == 2) begin
        if (a[5:3] < 7) m_cwl = 9 + int'(a[5:3]);
      end
    end
  endtask

  // One clock: model the edge, then compare every output 1 time unit later.
  task automatic tick();
    logic [15:0] ob;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    for (int i = 0; i < 16; i++) ob[i] = m_open[i];
    chk("cmd_valid", 64'(cmd_valid), 64'(e_valid));
    if (!e_dropped) chk("cmd_code", 64'(cmd_code), 64'(e_code));
    if (e_valid) begin
      chk("cmd_bank", 64'(cmd_bank), 64'(e_bank));
      chk("cmd_row", 64'(cmd_row), 64'(e_row));
      chk("cmd_col", 64'(cmd_col), 64'(e_col));
    end
    chk("proto_err", 64'(proto_err), 64'(e_proto));
    chk("par_err", 64'(par_err), 64'(e_par));
    chk("open_banks", 64'(open_banks), 64'(ob));
    chk("rd_en", 64'(rd_en), 64'(rd_exp[cyc]));
    chk("wr_en", 64'(wr_en), 64'(wr_exp[cyc]));
    chk("cl", 64'(cl), 64'(m_cl));
    chk("cwl", 64'(cwl), 64'(m_cwl));
    chk("al", 64'(al), 64'(m_al));
    chk("bl", 64'(bl), 64'(m_bl));
  endtask

  initial begin
    int c_n, first, last, run, maxrun;
    // 1: reset and MR0
    do_nop();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_cl", 64'(cl), 64'd9);
    chk("rst_bl", 64'(bl), 64'd8);
    do_nop(); tick();
    do_mrs(0, 14'h0010); tick();
    chk("t1_cl", 64'(cl), 64'd11);
    chk("t1_code", 64'(cmd_code), 64'd6);
    chk("t1_proto", 64'(proto_err), 64'd0);

    // 2: MR1 AL, ACT + CAS_R window
    do_mrs(1, 14'h0008); tick();
    chk("t2_al", 64'(al), 64'd10);
    do_act(3, 17'h1ABCD); tick();
    chk("t2_row", 64'(cmd_row), 64'h1ABCD);
    do_rd(3, 'h40); tick();
    c_n = cyc; first = -1; last = -1;
    do_nop();
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rd_en) begin if (first < 0) first = cyc; last = cyc; end
    end
    chk("t2_rd_first", 64'(first), 64'(c_n + 21));
    chk("t2_rd_last", 64'(last), 64'(c_n + 24));

    // 3: CAS_W to closed bank, double ACT
    do_wr(5, 'h10); tick();
    chk("t3_code", 64'(cmd_code), 64'd3);
    chk("t3_proto", 64'(proto_err), 64'd1);
    do_nop(); tick();
    chk("t3_proto_clr", 64'(proto_err), 64'd0);
    do_act(5, 17'h00123); tick();
    chk("t3_act1", 64'(proto_err), 64'd0);
    do_act(5, 17'h00456); tick();
    chk("t3_act2", 64'(proto_err), 64'd1);
    do_nop(); repeat (30) tick();

    // 4: back-to-back reads with an MRS in between
    do_rd(3, 'h80); tick();
    c_n = cyc;
    do_nop(); tick();
    do_mrs(2, 14'h0008); tick();
    do_nop(); tick();
    do_rd(3, 'h88); tick();
    do_nop();
    first = -1; run = 0; maxrun = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rd_en) begin
        if (first < 0) first = cyc;
        run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
    end
    chk("t4_first", 64'(first), 64'(c_n + 21));
    chk("t4_run", 64'(maxrun), 64'd8);

    // 5: PRE-all, REF legality
    do_pre(0, 1); tick();
    do_act(0, 17'h00001); tick();
    do_act(7, 17'h00002); tick();
    do_pre(2, 1); tick();
    chk("t5_open", 64'(open_banks), 64'd0);
    do_ref(); tick();
    chk("t5_ref_ok", 64'(proto_err), 64'd0);
    do_act(2, 17'h00003); tick();
    do_ref(); tick();
    chk("t5_ref_bad", 64'(proto_err), 64'd1);
    do_pre(0, 1); tick();

`ifdef DDR_CMD_PARITY_EN
    // 6: parity error drops the command
    set_pins(0, 0, 0, 0, 0, 1, 14'h0055, 1); tick();
    chk("t6_par", 64'(par_err), 64'd1);
    chk("t6_valid", 64'(cmd_valid), 64'd0);
    chk("t6_open", 64'(open_banks), 64'd0);
`endif

    // Reset in the middle of a read burst
    do_act(3, 17'h00010); tick();
    do_rd(3, 'h4); tick();
    do_nop(); repeat (22) tick();
    do_nop(); rst = 1'b1; tick();
    chk("rst_mid_rd", 64'(rd_en), 64'd0);
    do_nop(); repeat (3) tick();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      bit flip;
      flip = 0;
`ifdef DDR_CMD_PARITY_EN
      flip = ($urandom_range(9) == 0);
`endif
      if ($urandom_range(60) == 0) begin
        do_nop(); rst = 1'b1;
      end else if ($urandom_range(4) == 0) begin
        set_pins(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom_range(15)), 14'($urandom), 0);
      end else begin
        set_pins(0, ($urandom_range(3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom_range(15)), 14'($urandom), flip);
      end
      tick();
    end
    do_nop(); repeat (50) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
